// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
`timescale 1ns/1ps
package fetch_stage_pkg;

  typedef logic [31:0] regval_t;

  localparam regval_t     NOP              = 32'h8000_0000;
  localparam regval_t     DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_ISSUE       = 2'd0;
  localparam fetch_state_t ST_WAIT        = 2'd1;
  localparam fetch_state_t ST_PRESENT     = 2'd2;
  localparam fetch_state_t ST_BRANCH_WAIT = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage links: fetch-to-decode, write-to-fetch redirect and instruction memory.
`timescale 1ns/1ps
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  regval_t pc;
  regval_t instruction;
  logic    is_valid;
  logic    hold;
  logic    is_pc_changing;
  logic    early_flush;
  logic    has_flushed;
  regval_t next_pc;
  logic    mem_read;
  regval_t mem_address;
  logic    mem_waitrequest;
  logic    mem_readdatavalid;
  regval_t mem_readdata;

  modport master (
    output pc, instruction, is_valid, mem_read, mem_address,
    input  hold, is_pc_changing, early_flush, has_flushed, next_pc,
           mem_waitrequest, mem_readdatavalid, mem_readdata
  );

  modport slave (
    input  pc, instruction, is_valid, mem_read, mem_address,
    output hold, is_pc_changing, early_flush, has_flushed, next_pc,
           mem_waitrequest, mem_readdatavalid, mem_readdata
  );

endinterface

// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, issues one instruction-memory read at a time
// and presents each {pc, instruction} to decode under valid/hold flow control.
`timescale 1ns/1ps
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter regval_t     RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  fetch_state_t state;
  regval_t      fetch_pc;
  regval_t      held_addr;
  logic         held_valid;
  logic         drop;
  logic         pending_change;
  logic         accepted;

  assign accepted        = (state == ST_ISSUE) && !bus.mem_waitrequest;
  assign bus.mem_read    = (state == ST_ISSUE) && !reset;
  // A redirect during a stalled request must not disturb the address on the bus.
  assign bus.mem_address = held_valid ? held_addr : fetch_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_ISSUE;
      fetch_pc        <= RESET_PC;
      held_addr       <= RESET_PC;
      held_valid      <= 1'b0;
      drop            <= 1'b0;
      pending_change  <= 1'b0;
      bus.pc          <= RESET_PC;
      bus.instruction <= NOP;
      bus.is_valid    <= 1'b0;
    end else begin
      if (accepted)
        held_valid <= 1'b0;

      if (bus.has_flushed) begin
        fetch_pc        <= bus.next_pc;
        bus.is_valid    <= 1'b0;
        bus.instruction <= NOP;
        pending_change  <= 1'b0;
        case (state)
          ST_ISSUE: begin
            drop <= 1'b1;
            if (accepted) begin
              state <= ST_WAIT;
            end else if (!held_valid) begin
              held_addr  <= fetch_pc;
              held_valid <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (bus.mem_readdatavalid) begin
              drop  <= 1'b0;
              state <= ST_ISSUE;
            end else begin
              drop <= 1'b1;
            end
          end
          default: state <= ST_ISSUE;
        endcase
      end else if (bus.early_flush) begin
        bus.is_valid    <= 1'b0;
        bus.instruction <= NOP;
        // Outstanding reads still complete (one in flight at most); the
        // pending flag then steers the discard into BRANCH_WAIT.
        case (state)
          ST_ISSUE: begin
            drop           <= 1'b1;
            pending_change <= 1'b1;
            if (accepted)
              state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.mem_readdatavalid) begin
              drop  <= 1'b0;
              state <= ST_BRANCH_WAIT;
            end else begin
              drop           <= 1'b1;
              pending_change <= 1'b1;
            end
          end
          ST_PRESENT: state <= ST_BRANCH_WAIT;
          default: ;
        endcase
      end else begin
        case (state)
          ST_ISSUE: begin
            if (bus.is_pc_changing)
              pending_change <= 1'b1;
            if (accepted)
              state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.is_pc_changing)
              pending_change <= 1'b1;
            if (bus.mem_readdatavalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= (pending_change || bus.is_pc_changing) ? ST_BRANCH_WAIT : ST_ISSUE;
              end else begin
                bus.pc          <= fetch_pc;
                bus.instruction <= bus.mem_readdata;
                bus.is_valid    <= 1'b1;
                fetch_pc        <= fetch_pc + regval_t'(PC_STEP);
                state           <= ST_PRESENT;
              end
            end
          end
          ST_PRESENT: begin
            if (!bus.hold) begin
              bus.is_valid    <= 1'b0;
              bus.instruction <= NOP;
              state <= (pending_change || bus.is_pc_changing) ? ST_BRANCH_WAIT : ST_ISSUE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle-latency instruction memory model.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic mem_en;
  regval_t req_log[$];

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic regval_t memval(input regval_t a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return 32'hA000_0000 | a;
  endfunction

  // Memory: accepts when mem_read && !waitrequest, answers the next cycle.
  always @(posedge clock) begin
    bus.mem_readdatavalid <= 1'b0;
    if (mem_en && bus.mem_read && !bus.mem_waitrequest) begin
      bus.mem_readdatavalid <= 1'b1;
      bus.mem_readdata      <= memval(bus.mem_address);
      req_log.push_back(bus.mem_address);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_present(input string tag, input regval_t p, input regval_t ins);
    check({tag, "_valid"}, 32'(bus.is_valid), 32'd1);
    check({tag, "_pc"}, bus.pc, p);
    check({tag, "_ins"}, bus.instruction, ins);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.is_valid), 32'd0);
    check({tag, "_ins"}, bus.instruction, NOP);
  endtask

  regval_t exp_log[$];

  initial begin
    checks = 0;
    failures = 0;
    mem_en = 1'b1;
    reset = 1'b1;
    bus.hold = 1'b0;
    bus.is_pc_changing = 1'b0;
    bus.early_flush = 1'b0;
    bus.has_flushed = 1'b0;
    bus.next_pc = '0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata = '0;

    tick();
    tick();
    check_idle("reset");
    check("reset_pc", bus.pc, 32'h0);
    check("reset_memread", 32'(bus.mem_read), 32'd0);
    reset = 1'b0;
    #1;
    check("issue0_read", 32'(bus.mem_read), 32'd1);
    check("issue0_addr", bus.mem_address, 32'h0);

    // Sequential fetch of 0 and 4
    tick();
    check("wait0_read", 32'(bus.mem_read), 32'd0);
    check_idle("wait0");
    tick();
    check_present("pres0", 32'h0, 32'h1111_1111);
    tick();
    check_idle("gap0");
    check("issue4_addr", bus.mem_address, 32'h4);
    tick();
    tick();
    check_present("pres4", 32'h4, 32'h2222_2222);

    // Hold while presenting pc=8
    tick();
    tick();
    tick();
    check_present("pres8", 32'h8, 32'hA000_0008);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_present("hold8", 32'h8, 32'hA000_0008);
      check("hold8_read", 32'(bus.mem_read), 32'd0);
    end
    bus.hold = 1'b0;
    tick();
    check_idle("after_hold");
    check("issueC_addr", bus.mem_address, 32'hC);

    // Stalled request at 0xC redirected to 0x100
    bus.mem_waitrequest = 1'b1;
    bus.has_flushed = 1'b1;
    bus.next_pc = 32'h100;
    tick();
    bus.has_flushed = 1'b0;
    check("stallC_addr1", bus.mem_address, 32'hC);
    check("stallC_read1", 32'(bus.mem_read), 32'd1);
    tick();
    check("stallC_addr2", bus.mem_address, 32'hC);
    bus.mem_waitrequest = 1'b0;
    tick();
    check("dropC_wait", 32'(bus.mem_read), 32'd0);
    tick();
    check_idle("dropC");
    check("issue100_addr", bus.mem_address, 32'h100);
    tick();
    tick();
    check_present("pres100", 32'h100, 32'hA000_0100);

    // Redirect while presenting: go to 0x10
    bus.has_flushed = 1'b1;
    bus.next_pc = 32'h10;
    tick();
    bus.has_flushed = 1'b0;
    check_idle("redir10");
    check("issue10_addr", bus.mem_address, 32'h10);

    // Control transfer noted during WAIT at 0x10
    tick();
    bus.is_pc_changing = 1'b1;
    tick();
    bus.is_pc_changing = 1'b0;
    check_present("pres10", 32'h10, 32'hA000_0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bw10_read", 32'(bus.mem_read), 32'd0);
      check_idle("bw10");
    end
    bus.has_flushed = 1'b1;
    bus.next_pc = 32'h40;
    tick();
    bus.has_flushed = 1'b0;
    check("issue40_read", 32'(bus.mem_read), 32'd1);
    check("issue40_addr", bus.mem_address, 32'h40);
    tick();
    tick();
    check_present("pres40", 32'h40, 32'hA000_0040);

    // Early flush while presenting pc=0x20
    bus.has_flushed = 1'b1;
    bus.next_pc = 32'h20;
    tick();
    bus.has_flushed = 1'b0;
    tick();
    tick();
    check_present("pres20", 32'h20, 32'hA000_0020);
    bus.early_flush = 1'b1;
    tick();
    bus.early_flush = 1'b0;
    check_idle("eflush20");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("eflush20_read", 32'(bus.mem_read), 32'd0);
    end
    bus.has_flushed = 1'b1;
    bus.next_pc = 32'h200;
    tick();
    bus.has_flushed = 1'b0;
    check("issue200_addr", bus.mem_address, 32'h200);

    // Reset during WAIT; stale response must be ignored
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst_wait");
    check("rst_wait_pc", bus.pc, 32'h0);
    #1;
    check("rst_issue_read", 32'(bus.mem_read), 32'd1);
    check("rst_issue_addr", bus.mem_address, 32'h0);
    tick();
    check_idle("rst_stale");
    tick();
    check_present("rst_pres0", 32'h0, 32'h1111_1111);

    exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h10, 32'h40, 32'h20, 32'h200, 32'h0};
    check("req_count", 32'(req_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < req_log.size())
        check("req_addr", req_log[i], exp_log[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
